// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder
// Brief    : Byte FIFO that feeds a UART transmitter via a tx_enable/tx_busy
//            handshake. tx_busy comes from the baud-clock domain and is
//            resynchronised. A request that never sees busy rise is abandoned
//            after REQ_TIMEOUT cycles and flagged.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
    parameter int DEPTH       = 16,
    parameter int REQ_TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     flush,
    output logic [7:0]               tx_input,
    output logic                     tx_enable,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     tx_timeout
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_TMR_W = $clog2(REQ_TIMEOUT + 1);

    localparam logic [c_AW:0]      c_DEPTH_CNT = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]      c_CNT_ONE   = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0]    c_PTR_ONE   = c_AW'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    // Last timer value before the request is abandoned: entry cycle counts as 0.
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(REQ_TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_REQ       = 2'd1;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd2;

    logic [7:0]         r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic               r_busy_meta;
    logic               r_busy_s;
    logic [1:0]         r_state;
    logic [7:0]         r_tx_input;
    logic               r_tx_enable;
    logic               r_tx_timeout;
    logic [c_TMR_W-1:0] r_timer;

    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_head;

    // Handshake decode: flush wins over both push and pop in the same cycle.
    always_comb begin
        wr_ready = (r_count < c_DEPTH_CNT);
        w_push   = wr_valid && wr_ready && !flush;
        w_pop    = (r_state == c_ST_IDLE) && (r_count != '0) && !r_busy_s && !flush;
        w_head   = r_mem[r_rd_ptr];
    end

    // Storage array; contents need no reset since the count guards every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Two-flop resynchroniser for the baud-domain busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_meta <= 1'b0;
            r_busy_s    <= 1'b0;
        end else begin
            r_busy_meta <= tx_busy;
            r_busy_s    <= r_busy_meta;
        end
    end

    // Request sequencer: pop into tx_input, hold tx_enable until busy is seen,
    // then wait for the transmitter to finish. Flush deliberately has no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_tx_input   <= 8'h00;
            r_tx_enable  <= 1'b0;
            r_tx_timeout <= 1'b0;
            r_timer      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_input  <= w_head;
                        r_tx_enable <= 1'b1;
                        r_timer     <= '0;
                        r_state     <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (r_busy_s) begin
                        r_tx_enable <= 1'b0;
                        r_state     <= c_ST_WAIT_DONE;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_tx_enable  <= 1'b0;
                        r_tx_timeout <= 1'b1;
                        r_state      <= c_ST_IDLE;
                    end else begin
                        r_timer <= r_timer + c_TMR_ONE;
                    end
                end
                c_ST_WAIT_DONE: begin
                    if (!r_busy_s) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_tx_enable <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_count = r_count;
    assign tx_input   = r_tx_input;
    assign tx_enable  = r_tx_enable;
    assign tx_timeout = r_tx_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_feeder
// Brief    : Self-checking bench for uart_tx_feeder with a queue-based
//            reference model, a behavioural transmitter and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

    localparam int DEPTH       = 16;
    localparam int REQ_TIMEOUT = 10;

    localparam int MODE_TIED0 = 0;
    localparam int MODE_HIGH  = 1;
    localparam int MODE_AUTO  = 2;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_WAIT = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_valid = 1'b0;
    logic       flush    = 1'b0;
    logic       tx_busy  = 1'b0;
    logic       wr_ready;
    logic [7:0] tx_input;
    logic       tx_enable;
    logic [4:0] fifo_count;
    logic       tx_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .REQ_TIMEOUT (REQ_TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .flush      (flush),
        .tx_input   (tx_input),
        .tx_enable  (tx_enable),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .tx_timeout (tx_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural transmitter: busy rises two cycles after a request and stays
    // up for hold_len cycles; can also be tied low or forced high.
    int tx_mode  = MODE_TIED0;
    int hold_len = 100;
    int hold_cnt = 0;
    int dly      = 0;
    always @(negedge clk) begin
        case (tx_mode)
            MODE_TIED0: begin tx_busy = 1'b0; hold_cnt = 0; dly = 0; end
            MODE_HIGH:  begin tx_busy = 1'b1; hold_cnt = 0; dly = 0; end
            default: begin
                if (tx_busy) begin
                    if (hold_cnt == 0) tx_busy = 1'b0;
                    else hold_cnt--;
                end else if (tx_enable) begin
                    dly++;
                    if (dly >= 2) begin
                        tx_busy  = 1'b1;
                        hold_cnt = hold_len;
                        dly      = 0;
                    end
                end else begin
                    dly = 0;
                end
            end
        endcase
    end

    // Reference model: a byte queue plus the transfer phase, stepped per edge.
    byte unsigned m_q[$];
    logic [7:0]   m_tx    = 8'h00;
    bit           m_to    = 1'b0;
    int           m_phase = PH_IDLE;
    int           m_age   = 0;
    bit           m_s1    = 1'b0;
    bit           m_s2    = 1'b0;
    int           m_n;
    bit           m_bs, m_do_pop, m_do_push;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_tx = 8'h00; m_to = 1'b0; m_phase = PH_IDLE; m_age = 0;
            m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            m_n       = m_q.size();
            m_bs      = m_s2;
            m_do_pop  = (m_phase == PH_IDLE) && (m_n > 0) && !m_bs && !flush;
            m_do_push = wr_valid && (m_n < DEPTH) && !flush;
            if (flush) begin
                m_q.delete();
            end else begin
                if (m_do_pop)  m_tx = m_q.pop_front();
                if (m_do_push) m_q.push_back(wr_data);
            end
            if (m_phase == PH_IDLE) begin
                if (m_do_pop) begin m_phase = PH_REQ; m_age = 0; end
            end else if (m_phase == PH_REQ) begin
                m_age++;
                if (m_bs) m_phase = PH_WAIT;
                else if (m_age >= REQ_TIMEOUT) begin m_to = 1'b1; m_phase = PH_IDLE; end
            end else begin
                if (!m_bs) m_phase = PH_IDLE;
            end
            m_s2 = m_s1;
            m_s1 = tx_busy;
        end
    end

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        check("cyc_fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("cyc_wr_ready",   32'(wr_ready),   32'(m_q.size() < DEPTH));
        check("cyc_tx_enable",  32'(tx_enable),  32'(m_phase == PH_REQ));
        check("cyc_tx_input",   32'(tx_input),   32'(m_tx));
        check("cyc_tx_timeout", 32'(tx_timeout), 32'(m_to));
    end

    // Log of bytes presented at each rising tx_enable.
    byte unsigned sent_q[$];
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (tx_enable && !prev_en) sent_q.push_back(tx_input);
        prev_en = tx_enable;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        tick(1);
        wr_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int limit);
        int k;
        k = 0;
        while ((fifo_count != 0 || tx_enable || tx_busy) && k < limit) begin
            tick(1);
            k++;
        end
        check("drain_within_budget", 32'(k < limit), 32'(1));
        tick(6);
    endtask

    logic [7:0] fill_d [18];
    logic [7:0] sim_d  [5];
    logic [7:0] fl_d   [5];
    int         base;
    int         en_cyc;
    int         guard;

    initial begin
        // Reset state
        #2;
        check("rst_fifo_count", 32'(fifo_count), 32'(0));
        check("rst_tx_enable",  32'(tx_enable),  32'(0));
        check("rst_tx_input",   32'(tx_input),   32'(8'h00));
        check("rst_wr_ready",   32'(wr_ready),   32'(1));
        check("rst_tx_timeout", 32'(tx_timeout), 32'(0));
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Reset asserted with one byte in flight and two queued
        tx_mode  = MODE_AUTO;
        hold_len = 100;
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_fifo_count", 32'(fifo_count), 32'(0));
        check("midrst_tx_enable",  32'(tx_enable),  32'(0));
        check("midrst_tx_input",   32'(tx_input),   32'(8'h00));
        check("midrst_wr_ready",   32'(wr_ready),   32'(1));
        tick(1);
        rst_n = 1'b1;
        wait_quiet(400);

        // Single byte: enable one cycle after push, held until busy is seen
        base = sent_q.size();
        push_byte(8'hA5);
        check("single_queued", 32'(fifo_count), 32'(1));
        tick(1);
        check("single_enable", 32'(tx_enable), 32'(1));
        check("single_data",   32'(tx_input),  32'(8'hA5));
        check("single_popped", 32'(fifo_count), 32'(0));
        en_cyc = 0;
        guard  = 0;
        while (tx_enable && guard < 40) begin en_cyc++; tick(1); guard++; end
        check("single_enable_cycles", 32'(en_cyc), 32'(4));
        wait_quiet(400);
        check("single_sent_count", 32'(sent_q.size() - base), 32'(1));

        // Fill: one byte in flight, sixteen queued, the rest refused
        base     = sent_q.size();
        hold_len = 400;
        for (int i = 0; i < 18; i++) fill_d[i] = 8'($urandom);
        for (int i = 0; i < 18; i++) begin
            wr_data  = fill_d[i];
            wr_valid = 1'b1;
            tick(1);
        end
        wr_valid = 1'b0;
        check("fill_count", 32'(fifo_count), 32'(16));
        check("fill_ready", 32'(wr_ready),   32'(0));
        hold_len = 20;
        wait_quiet(3000);
        check("fill_sent_count", 32'(sent_q.size() - base), 32'(17));
        for (int i = 0; i < 17; i++)
            if (base + i < sent_q.size())
                check("fill_order", 32'(sent_q[base + i]), 32'(fill_d[i]));

        // Push coinciding with a pop at count 4
        base    = sent_q.size();
        tx_mode = MODE_HIGH;
        tick(4);
        for (int i = 0; i < 5; i++) sim_d[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) push_byte(sim_d[i]);
        check("simul_pre_count",  32'(fifo_count), 32'(4));
        check("simul_pre_enable", 32'(tx_enable),  32'(0));
        hold_len = 20;
        tx_mode  = MODE_AUTO;
        tick(2);
        push_byte(sim_d[4]);
        check("simul_count",  32'(fifo_count), 32'(4));
        check("simul_enable", 32'(tx_enable),  32'(1));
        check("simul_data",   32'(tx_input),   32'(sim_d[0]));
        wait_quiet(1000);
        check("simul_sent_count", 32'(sent_q.size() - base), 32'(5));
        for (int i = 0; i < 5; i++)
            if (base + i < sent_q.size())
                check("simul_order", 32'(sent_q[base + i]), 32'(sim_d[i]));

        // Flush while the first byte is being transmitted
        base     = sent_q.size();
        hold_len = 100;
        for (int i = 0; i < 5; i++) fl_d[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) push_byte(fl_d[i]);
        guard = 0;
        while (!tx_busy && guard < 20) begin tick(1); guard++; end
        check("flush_busy_seen", 32'(tx_busy), 32'(1));
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_count", 32'(fifo_count), 32'(0));
        check("flush_ready", 32'(wr_ready),   32'(1));
        wait_quiet(400);
        tick(20);
        check("flush_sent_count", 32'(sent_q.size() - base), 32'(1));
        if (sent_q.size() > base)
            check("flush_inflight_byte", 32'(sent_q[base]), 32'(fl_d[0]));
        check("flush_no_enable", 32'(tx_enable), 32'(0));

        // Timeout with busy tied low
        tx_mode = MODE_TIED0;
        tick(4);
        check("to_pre_flag", 32'(tx_timeout), 32'(0));
        push_byte(8'h3C);
        tick(1);
        en_cyc = 0;
        guard  = 0;
        while (tx_enable && guard < 40) begin en_cyc++; tick(1); guard++; end
        check("to_enable_cycles", 32'(en_cyc),     32'(10));
        check("to_flag",          32'(tx_timeout), 32'(1));
        check("to_data",          32'(tx_input),   32'(8'h3C));
        check("to_count",         32'(fifo_count), 32'(0));
        tick(5);
        check("to_idle_enable", 32'(tx_enable),  32'(0));
        check("to_sticky",      32'(tx_timeout), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
